// File: rtl/core_writeback_pkg.sv
// Shared core types plus the writeback entry carried through the load buffer
// and the writeback source mux.
package core_writeback_pkg;

    typedef logic [3:0]  reg_num;
    typedef logic [31:0] word;
    typedef logic [29:0] ptr;
    typedef logic [4:0]  psr_mode;

    localparam reg_num R15_PC = 4'd15;

    typedef struct packed {
        reg_num  rd;
        word     value;
        psr_mode mode;
    } wb_entry;

    function automatic logic is_pc(input reg_num r);
        return r == R15_PC;
    endfunction

endpackage

// File: rtl/core_writeback_fifo.sv
// Load buffer: LD_DEPTH-entry FIFO with pointers one bit wider than the index,
// so full and empty are told apart by the wrap bit.
module core_writeback_fifo
    import core_writeback_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  wb_entry                     push_data,
    input  logic                        pop,
    output wb_entry                     head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(LD_DEPTH):0]   space
);
    localparam int AW = $clog2(LD_DEPTH);

    wb_entry       mem_q [LD_DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign count = wptr_q - rptr_q;
    assign full  = count == (AW + 1)'(LD_DEPTH);
    assign empty = wptr_q == rptr_q;
    assign space = (AW + 1)'(LD_DEPTH) - count;
    assign head  = mem_q[rptr_q[AW-1:0]];

    // A push into a full buffer lands in the slot being popped the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // NOTE: storage is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/core_writeback.sv
// Writeback stage: merges the stallable ALU and the buffered load unit onto the
// register file's single write port. CORE_WB_SCOREBOARD_EN adds the pending mask.
module core_writeback
    import core_writeback_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  reg_num                      alu_rd,
    input  word                         alu_value,
    input  psr_mode                     alu_mode,
    input  logic                        ld_valid,
    input  reg_num                      ld_rd,
    input  word                         ld_value,
    input  psr_mode                     ld_mode,
    output logic [$clog2(LD_DEPTH):0]   ld_space,
    input  logic                        issue_valid,
    input  reg_num                      issue_rd,
    output logic [15:0]                 pending,
    output logic                        wr_enable,
    output reg_num                      wr_r,
    output word                         wr_value,
    output psr_mode                     wr_mode,
    output logic                        branch,
    output ptr                          branch_target
);
    wb_entry alu_entry, ld_entry, head, sel;
    logic    fifo_full, fifo_empty, push, pop, sel_valid;

    assign alu_entry = '{rd: alu_rd, value: alu_value, mode: alu_mode};
    assign ld_entry  = '{rd: ld_rd,  value: ld_value,  mode: ld_mode};

    core_writeback_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ld_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .space     (ld_space)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        sel       = head;
        sel_valid = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        alu_ready = 1'b0;
        if (fifo_full) begin
            // A load arriving now has no space and is dropped.
            sel_valid = 1'b1;
            pop       = 1'b1;
        end else if (alu_valid) begin
            sel       = alu_entry;
            sel_valid = 1'b1;
            alu_ready = 1'b1;
            push      = ld_valid;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
            push      = ld_valid;
        end else if (ld_valid) begin
            sel       = ld_entry;
            sel_valid = 1'b1;
        end
    end

    wb_entry wr_q, wr_d;
    logic    wr_enable_q, wr_enable_d, branch_q, branch_d;
    ptr      target_q, target_d;

    always_comb begin
        wr_enable_d = sel_valid;
        wr_d        = wr_q;
        branch_d    = 1'b0;
        target_d    = target_q;
        if (sel_valid) begin
            wr_d = sel;
            if (is_pc(sel.rd)) begin
                branch_d = 1'b1;
                target_d = sel.value[31:2];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable_q <= 1'b0;
            wr_q        <= '0;
            branch_q    <= 1'b0;
            target_q    <= '0;
        end else begin
            wr_enable_q <= wr_enable_d;
            wr_q        <= wr_d;
            branch_q    <= branch_d;
            target_q    <= target_d;
        end
    end

    assign wr_enable     = wr_enable_q;
    assign wr_r          = wr_q.rd;
    assign wr_value      = wr_q.value;
    assign wr_mode       = wr_q.mode;
    assign branch        = branch_q;
    assign branch_target = target_q;

    a_ld_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ld_valid && ld_space == '0))
        else $error("load presented with no buffer space; dropped");

`ifdef CORE_WB_SCOREBOARD_EN
    logic [15:0] pending_q, pending_d;

    // Set after clear: a same-cycle issue to the written register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (sel_valid)   pending_d[sel.rd]   = 1'b0;
        if (issue_valid) pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign pending = pending_q;

    a_issue_hazard: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && pending_q[issue_rd]))
        else $error("issue to a register with an outstanding write");
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd};
    assign pending      = '0;
`endif

endmodule

// File: tb/tb_core_writeback.sv
// Bench for core_writeback: directed scenarios plus randomized traffic checked
// against a queue-based model of the writeback priority rules.
module tb_core_writeback;
    import core_writeback_pkg::*;

    localparam int LD_DEPTH = 2;
    localparam int SW = $clog2(LD_DEPTH) + 1;
`ifdef CORE_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic clk, rst;
    logic alu_valid, alu_ready, ld_valid, issue_valid;
    reg_num alu_rd, ld_rd, issue_rd, wr_r;
    word alu_value, ld_value, wr_value;
    psr_mode alu_mode, ld_mode, wr_mode;
    logic [SW-1:0] ld_space;
    logic [15:0] pending;
    logic wr_enable, branch;
    ptr branch_target;

    core_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_value(alu_value), .alu_mode(alu_mode),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_value(ld_value), .ld_mode(ld_mode),
        .ld_space(ld_space),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
        .wr_enable(wr_enable), .wr_r(wr_r), .wr_value(wr_value), .wr_mode(wr_mode),
        .branch(branch), .branch_target(branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state and expectations
    wb_entry m_q[$];
    logic [15:0] m_pending;
    logic e_ready, c_ready;
    logic [SW-1:0] e_space, c_space;
    logic e_wen, e_branch;
    wb_entry e_wr;
    ptr e_target;
    logic [15:0] e_pending;

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_value = '0; alu_mode = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_value = '0; ld_mode = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pending = '0;
        e_wen = 1'b0; e_wr = '0; e_branch = 1'b0; e_target = '0; e_pending = '0;
    endtask

    // One clock: sample combinational outputs mid-cycle, advance the model, then
    // step past the rising edge so registered outputs can be compared.
    task automatic tick();
        wb_entry w;
        logic wv;
        @(negedge clk);
        c_ready = alu_ready;
        c_space = ld_space;
        e_ready = alu_valid && (m_q.size() < LD_DEPTH);
        e_space = SW'(LD_DEPTH - m_q.size());
        wv = 1'b1;
        w = '0;
        if (m_q.size() == LD_DEPTH) begin
            w = m_q.pop_front();
        end else if (alu_valid) begin
            w = '{alu_rd, alu_value, alu_mode};
            if (ld_valid) m_q.push_back('{ld_rd, ld_value, ld_mode});
        end else if (m_q.size() != 0) begin
            w = m_q.pop_front();
            if (ld_valid) m_q.push_back('{ld_rd, ld_value, ld_mode});
        end else if (ld_valid) begin
            w = '{ld_rd, ld_value, ld_mode};
        end else begin
            wv = 1'b0;
        end
        e_wen = wv;
        e_branch = 1'b0;
        if (wv) begin
            e_wr = w;
            m_pending[w.rd] = 1'b0;
            if (w.rd == 4'd15) begin
                e_branch = 1'b1;
                e_target = w.value[31:2];
            end
        end
        if (issue_valid) m_pending[issue_rd] = 1'b1;
        e_pending = SB_EN ? m_pending : 16'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({wr_enable, wr_r, wr_value, wr_mode} !== '0) begin n_fail++;
            $display("FAIL reset_wr_port: got %0b/%0d/%h/%h want 0", wr_enable, wr_r, wr_value, wr_mode); end
        n_checks++; if ({branch, branch_target} !== '0) begin n_fail++;
            $display("FAIL reset_branch: got %0b/%h want 0", branch, branch_target); end
        n_checks++; if (pending !== 16'h0) begin n_fail++;
            $display("FAIL reset_pending: got %h want 0", pending); end
        n_checks++; if (ld_space !== SW'(LD_DEPTH)) begin n_fail++;
            $display("FAIL reset_ld_space: got %0d want %0d", ld_space, LD_DEPTH); end
        rst = 1'b0;
    endtask

    task automatic test_alu_only();
        psr_mode m;
        m = psr_mode'($urandom);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 4'd3;
        tick();
        idle_inputs();
        n_checks++; if (pending[3] !== SB_EN) begin n_fail++;
            $display("FAIL alu_pending_set: got %0b want %0b", pending[3], SB_EN); end
        alu_valid = 1'b1; alu_rd = 4'd3; alu_value = 32'h0000_00AA; alu_mode = m;
        tick();
        idle_inputs();
        n_checks++; if (c_ready !== 1'b1) begin n_fail++;
            $display("FAIL alu_ready: got %0b want 1", c_ready); end
        n_checks++; if ({wr_enable, wr_r, wr_value, wr_mode} !== {1'b1, 4'd3, 32'hAA, m}) begin n_fail++;
            $display("FAIL alu_write: got %0b/%0d/%h/%h want 1/3/aa/%h", wr_enable, wr_r, wr_value, wr_mode, m); end
        n_checks++; if (pending[3] !== 1'b0) begin n_fail++;
            $display("FAIL alu_pending_clear: got %0b want 0", pending[3]); end
        tick();
        n_checks++; if (wr_enable !== 1'b0) begin n_fail++;
            $display("FAIL alu_idle_wen: got %0b want 0", wr_enable); end
    endtask

    task automatic test_collision();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'd1; alu_value = 32'h11;
        ld_valid = 1'b1; ld_rd = 4'd2; ld_value = 32'h22;
        tick();
        idle_inputs();
        n_checks++; if ({wr_enable, wr_r, wr_value} !== {1'b1, 4'd1, 32'h11} || c_space !== 2'd2) begin n_fail++;
            $display("FAIL coll_first: got %0b/%0d/%h space %0d want 1/1/11 space 2", wr_enable, wr_r, wr_value, c_space); end
        tick();
        n_checks++; if ({wr_enable, wr_r, wr_value} !== {1'b1, 4'd2, 32'h22} || c_space !== 2'd1) begin n_fail++;
            $display("FAIL coll_second: got %0b/%0d/%h space %0d want 1/2/22 space 1", wr_enable, wr_r, wr_value, c_space); end
        tick();
        n_checks++; if (wr_enable !== 1'b0 || c_space !== 2'd2) begin n_fail++;
            $display("FAIL coll_drained: got wen %0b space %0d want 0 space 2", wr_enable, c_space); end
    endtask

    task automatic test_fifo_full();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'd4; alu_value = 32'h44;
        ld_valid = 1'b1; ld_rd = 4'd6; ld_value = 32'h66;
        tick();
        alu_value = 32'h45; ld_rd = 4'd7; ld_value = 32'h77;
        tick();
        ld_valid = 1'b0; alu_value = 32'h46;
        tick();
        n_checks++; if (c_ready !== 1'b0 || c_space !== 2'd0) begin n_fail++;
            $display("FAIL full_stall: got ready %0b space %0d want 0 space 0", c_ready, c_space); end
        n_checks++; if ({wr_enable, wr_r, wr_value} !== {1'b1, 4'd6, 32'h66}) begin n_fail++;
            $display("FAIL full_head: got %0b/%0d/%h want 1/6/66", wr_enable, wr_r, wr_value); end
        tick();
        n_checks++; if (c_ready !== 1'b1 || {wr_r, wr_value} !== {4'd4, 32'h46}) begin n_fail++;
            $display("FAIL full_alu_resume: got ready %0b %0d/%h want 1 4/46", c_ready, wr_r, wr_value); end
        idle_inputs();
        tick();
        n_checks++; if ({wr_enable, wr_r, wr_value} !== {1'b1, 4'd7, 32'h77}) begin n_fail++;
            $display("FAIL full_second_load: got %0b/%0d/%h want 1/7/77", wr_enable, wr_r, wr_value); end
        tick();
        n_checks++; if (wr_enable !== 1'b0 || c_space !== 2'd2) begin n_fail++;
            $display("FAIL full_drained: got wen %0b space %0d want 0 space 2", wr_enable, c_space); end
    endtask

    task automatic test_branch();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'd15; alu_value = 32'h0000_1004;
        tick();
        idle_inputs();
        n_checks++; if ({branch, branch_target, wr_enable, wr_r} !== {1'b1, 30'h401, 1'b1, 4'd15}) begin n_fail++;
            $display("FAIL branch_pulse: got %0b/%h wen %0b r%0d want 1/401 wen 1 r15", branch, branch_target, wr_enable, wr_r); end
        tick();
        n_checks++; if (branch !== 1'b0) begin n_fail++;
            $display("FAIL branch_one_cycle: got %0b want 0", branch); end
    endtask

    task automatic test_scoreboard_race();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'd5; alu_value = 32'h55;
        issue_valid = 1'b1; issue_rd = 4'd5;
        tick();
        idle_inputs();
        n_checks++; if (pending[5] !== SB_EN || wr_r !== 4'd5) begin n_fail++;
            $display("FAIL race_set_wins: got pending5 %0b r%0d want %0b r5", pending[5], wr_r, SB_EN); end
        alu_valid = 1'b1; alu_rd = 4'd5; alu_value = 32'h56;
        tick();
        idle_inputs();
        n_checks++; if (pending !== 16'h0) begin n_fail++;
            $display("FAIL race_cleared: got %h want 0", pending); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'd7; alu_value = 32'h70;
        ld_valid = 1'b1; ld_rd = 4'd8; ld_value = 32'h80;
        tick();
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if ({wr_enable, wr_r, wr_value, wr_mode, branch, branch_target, pending} !== '0) begin n_fail++;
            $display("FAIL mid_reset_outputs: got wen %0b r%0d %h want all 0", wr_enable, wr_r, wr_value); end
        n_checks++; if (ld_space !== 2'd2) begin n_fail++;
            $display("FAIL mid_reset_space: got %0d want 2", ld_space); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        n_checks++; if (wr_enable !== 1'b0 || wr_r !== 4'd0 || c_space !== 2'd2) begin n_fail++;
            $display("FAIL mid_reset_no_load: got wen %0b r%0d space %0d want 0/0/2", wr_enable, wr_r, c_space); end
    endtask

    task automatic test_random();
        reg_num r;
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd = reg_num'($urandom); alu_value = $urandom; alu_mode = psr_mode'($urandom);
            ld_valid = (m_q.size() < LD_DEPTH) && ($urandom_range(0, 1) == 1);
            ld_rd = reg_num'($urandom); ld_value = $urandom; ld_mode = psr_mode'($urandom);
            r = reg_num'($urandom);
            issue_valid = ($urandom_range(0, 3) == 0) && !(SB_EN && m_pending[r]);
            issue_rd = r;
            tick();
            n_checks++; if (c_ready !== e_ready) begin n_fail++;
                $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, c_ready, e_ready); end
            n_checks++; if (c_space !== e_space) begin n_fail++;
                $display("FAIL rnd_space[%0d]: got %0d want %0d", i, c_space, e_space); end
            n_checks++; if (wr_enable !== e_wen || {wr_r, wr_value, wr_mode} !== e_wr) begin n_fail++;
                $display("FAIL rnd_write[%0d]: got %0b/%0d/%h/%h want %0b/%0d/%h/%h", i, wr_enable, wr_r, wr_value, wr_mode,
                         e_wen, e_wr.rd, e_wr.value, e_wr.mode); end
            n_checks++; if (branch !== e_branch || branch_target !== e_target) begin n_fail++;
                $display("FAIL rnd_branch[%0d]: got %0b/%h want %0b/%h", i, branch, branch_target, e_branch, e_target); end
            n_checks++; if (pending !== e_pending) begin n_fail++;
                $display("FAIL rnd_pending[%0d]: got %h want %h", i, pending, e_pending); end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_only();
        test_collision();
        test_fifo_full();
        test_branch();
        test_scoreboard_race();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
